// File: rtl/add_sequencer.sv
// Two-requester nibble-serial adder: one shared 4-bit ripple adder, round-robin arbitration, valid/ready response.
// Optional subtract support is compiled in with `define ADD_SEQ_SUB_EN.

module add_seq_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef ADD_SEQ_SUB_EN
    input  logic                 req0_sub,
    input  logic                 req1_sub,
`endif
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [4*WORDS-1:0]   req0_a,
    input  logic [4*WORDS-1:0]   req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [4*WORDS-1:0]   req1_a,
    input  logic [4*WORDS-1:0]   req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [4*WORDS-1:0]   rsp_sum,
    output logic                 rsp_cout,
    output logic                 busy
);
    localparam int W     = 4 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t           state_reg;
    logic [W-1:0]     a_reg;
    logic [W-1:0]     b_reg;
    logic [W-1:0]     sum_reg;
    logic             carry_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             id_reg;
    logic             last_reg;
    logic             rsp_valid_reg;
    logic             busy_reg;

    logic             grant0;
    logic             grant1;
    logic             sub_sel;
    logic [W-1:0]     a_in;
    logic [W-1:0]     b_in;
    logic [3:0]       nib_sum;
    logic [4:0]       carry_chain;
    logic [W-1:0]     sum_next;

    // Ties go to the requester that was not served last.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_reg == IDLE) begin
            grant0 = req0_valid & (~req1_valid | last_reg);
            grant1 = req1_valid & (~req0_valid | ~last_reg);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

`ifdef ADD_SEQ_SUB_EN
    assign sub_sel = grant1 ? req1_sub : req0_sub;
`else
    assign sub_sel = 1'b0;
`endif

    assign a_in = grant1 ? req1_a : req0_a;
    assign b_in = grant1 ? req1_b : req0_b;

    // Operands shift down a nibble per pass, so the adder always sees bits [3:0].
    assign carry_chain[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            add_seq_fa u_fa (
                .a    (a_reg[gi]),
                .b    (b_reg[gi]),
                .cin  (carry_chain[gi]),
                .s    (nib_sum[gi]),
                .cout (carry_chain[gi+1])
            );
        end
        if (WORDS > 1) begin : g_sum_wide
            assign sum_next = {nib_sum, sum_reg[W-1:4]};
        end else begin : g_sum_narrow
            assign sum_next = nib_sum;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            sum_reg       <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            id_reg        <= 1'b0;
            last_reg      <= 1'b1;
            rsp_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant0 || grant1) begin
                        a_reg     <= a_in;
                        // Subtraction is a + ~b + 1: invert b here, seed the carry with 1.
                        b_reg     <= sub_sel ? ~b_in : b_in;
                        carry_reg <= sub_sel;
                        id_reg    <= grant1;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= ADD;
                    end
                end
                ADD: begin
                    a_reg     <= a_reg >> 4;
                    b_reg     <= b_reg >> 4;
                    sum_reg   <= sum_next;
                    carry_reg <= carry_chain[4];
                    if (idx_reg == IDX_W'(WORDS - 1)) begin
                        idx_reg       <= '0;
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        last_reg      <= id_reg;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_id    = id_reg;
    assign rsp_sum   = sum_reg;
    assign rsp_cout  = carry_reg;
    assign busy      = busy_reg;

endmodule

// File: doc/add_sequencer.md
ADD_SEQUENCER -- requirements
Module: add_sequencer

Interface
REQ-001 SHALL have parameter: WORDS, default 4, number of 4-bit nibble passes; operand width W = 4*WORDS.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: req0_valid  input  1  requester 0 has an operand pair.
REQ-005 SHALL have port: req0_ready  output  1  requester 0 handshake accepted this cycle.
REQ-006 SHALL have ports: req0_a, req0_b  input  W  requester 0 operands.
REQ-007 SHALL have ports: req1_valid, req1_ready, req1_a, req1_b, with the same directions, widths and meanings as REQ-004 to REQ-006, for requester 1.
REQ-008 SHALL have port: rsp_valid  output  1  result available.
REQ-009 SHALL have port: rsp_ready  input  1  consumer takes the result.
REQ-010 SHALL have port: rsp_id  output  1  index of the requester served.
REQ-011 SHALL have port: rsp_sum  output  W  result word.
REQ-012 SHALL have port: rsp_cout  output  1  carry out of the top nibble.
REQ-013 SHALL have port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL contain one shared 4-bit ripple adder built from full-adder cells; all arithmetic SHALL pass through it one nibble per cycle.
REQ-015 SHALL implement states IDLE, ADD and DONE.
REQ-016 In IDLE, SHALL assert at most one reqN_ready, combinationally from the valid inputs and the priority pointer; ready SHALL be 0 in ADD and DONE.
REQ-017 Arbitration: if one requester is valid, SHALL grant it; if both are valid, SHALL grant the one not served last (round-robin).
REQ-018 On handshake (valid & ready in IDLE), SHALL latch a, b and the id, clear the nibble index and carry register, and go to ADD.
REQ-019 In ADD at index i, SHALL add nibble i of a, nibble i of b and the carry register, write sum nibble i, store carry-out, and increment i.
REQ-020 After i = WORDS-1 completes, SHALL go to DONE; rsp_valid SHALL be high exactly WORDS+1 cycles after the accept cycle (5 for WORDS=4).
REQ-021 In DONE, rsp_valid = 1 and rsp_sum, rsp_cout and rsp_id SHALL be held stable until rsp_ready = 1; on that cycle SHALL go to IDLE and set the pointer to the served id.
REQ-022 Operand input changes after acceptance SHALL NOT affect the result.
REQ-023 Result SHALL equal (a + b) mod 2^W, with rsp_cout = bit W of a + b.
REQ-024 A new request SHALL NOT be accepted in the same cycle that the response handshake completes (minimum one IDLE cycle between jobs).

Reset
REQ-025 rst SHALL take priority over all other inputs in the cycle it is sampled.
REQ-026 On reset, SHALL set state = IDLE, rsp_valid = 0, rsp_sum = 0, rsp_cout = 0, rsp_id = 0, busy = 0, nibble index = 0 and carry = 0.
REQ-027 On reset, SHALL set the pointer to "last served = 1", so that req0 wins the first contention.
REQ-028 Reset during ADD or DONE SHALL abort the job with no response; the next cycle SHALL be IDLE with reset values.

Configuration
REQ-029 Macro ADD_SEQ_SUB_EN, when defined, SHALL add input ports req0_sub and req1_sub (1 bit each), latched at accept.
REQ-030 With ADD_SEQ_SUB_EN defined and sub = 1, SHALL compute a - b as a + ~b + 1: invert b nibbles and initialise carry to 1; rsp_cout = 1 means no borrow.
REQ-031 Without ADD_SEQ_SUB_EN, the sub ports SHALL be absent and the block SHALL always add.

Verification (WORDS=4)
REQ-032 req0 a=0x0001, b=0x0006 -> rsp_sum=0x0007, rsp_cout=0, rsp_id=0, rsp_valid 5 cycles after accept.
REQ-033 req1 a=0xFFFF, b=0xFFFF -> rsp_sum=0xFFFE, rsp_cout=1, rsp_id=1 (carry ripples across all nibbles).
REQ-034 Both valid after reset, rsp_ready=1, two jobs -> first rsp_id=0, second rsp_id=1; third contention -> rsp_id=0.
REQ-035 a=0x0F0F, b=0x00F1 with rsp_ready held 0 for 3 cycles in DONE -> rsp_sum=0x1000 stable, both reqN_ready=0, busy=1 until release.
REQ-036 rst pulsed in the second ADD cycle -> next cycle busy=0, rsp_valid=0; a subsequent contention grants req0.
REQ-037 ADD_SEQ_SUB_EN defined, a=0x0008, b=0x0009, sub=1 -> rsp_sum=0xFFFF, rsp_cout=0.
